// File: rtl/pong_frame_renderer_if.sv
// Position inputs from the game controller and the VGA video stream of pong_frame_renderer.
interface pong_frame_renderer_if #(
  parameter int XW = 11,
  parameter int YW = 10
);
  logic [YW-1:0] paddle_1_pos;
  logic [YW-1:0] paddle_2_pos;
  logic [XW-1:0] ball_pos_x;
  logic [YW-1:0] ball_pos_y;
  logic          hsync_n;
  logic          vsync_n;
  logic [11:0]   rgb;
  logic          de;
  logic          frame_tick;

  modport master (
    output paddle_1_pos, paddle_2_pos, ball_pos_x, ball_pos_y,
    input  hsync_n, vsync_n, rgb, de, frame_tick
  );

  modport slave (
    input  paddle_1_pos, paddle_2_pos, ball_pos_x, ball_pos_y,
    output hsync_n, vsync_n, rgb, de, frame_tick
  );
endinterface

// File: rtl/pong_frame_renderer.sv
// VGA timing generator, once-per-frame position shadowing and paddle/ball rasteriser.
// Optional dashed centre net is enabled by defining PONG_CENTER_NET_EN.
module pong_frame_renderer #(
  parameter int          H_ACTIVE       = 640,
  parameter int          H_FRONT        = 16,
  parameter int          H_SYNC         = 96,
  parameter int          H_BACK         = 48,
  parameter int          V_ACTIVE       = 480,
  parameter int          V_FRONT        = 10,
  parameter int          V_SYNC         = 2,
  parameter int          V_BACK         = 33,
  parameter int          PADDLE_1_X     = 20,
  parameter int          PADDLE_2_X     = 610,
  parameter int          PADDLE_WIDTH   = 10,
  parameter int          PADDLE_HEIGHT  = 80,
  parameter int          BALL_SIDE_SIZE = 10,
  parameter logic [11:0] FG_COLOR       = 12'hFFF,
  parameter logic [11:0] BG_COLOR       = 12'h000
) (
  input logic                  clk,
  input logic                  rst,
  pong_frame_renderer_if.slave vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int XW      = $clog2(H_ACTIVE + 1) + 1;
  localparam int YW      = $clog2(V_ACTIVE + 1) + 1;
  localparam int HCW     = $clog2(H_TOTAL);
  localparam int VCW     = $clog2(V_TOTAL);

  localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
  localparam logic [HCW-1:0] H_ACT_C  = HCW'(H_ACTIVE);
  localparam logic [HCW-1:0] HS_LO    = HCW'(H_ACTIVE + H_FRONT);
  localparam logic [HCW-1:0] HS_HI    = HCW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
  localparam logic [VCW-1:0] V_ACT_C  = VCW'(V_ACTIVE);
  localparam logic [VCW-1:0] V_LATCH  = VCW'(V_ACTIVE - 1);
  localparam logic [VCW-1:0] VS_LO    = VCW'(V_ACTIVE + V_FRONT);
  localparam logic [VCW-1:0] VS_HI    = VCW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [HCW-1:0] H_ONE    = HCW'(1);
  localparam logic [VCW-1:0] V_ONE    = VCW'(1);

  localparam logic [XW:0]    P1_LO    = (XW+1)'(PADDLE_1_X);
  localparam logic [XW:0]    P1_HI    = (XW+1)'(PADDLE_1_X + PADDLE_WIDTH);
  localparam logic [XW:0]    P2_LO    = (XW+1)'(PADDLE_2_X);
  localparam logic [XW:0]    P2_HI    = (XW+1)'(PADDLE_2_X + PADDLE_WIDTH);
  localparam logic [YW:0]    PAD_H_C  = (YW+1)'(PADDLE_HEIGHT);
  localparam logic [XW:0]    BALL_X_C = (XW+1)'(BALL_SIDE_SIZE);
  localparam logic [YW:0]    BALL_Y_C = (YW+1)'(BALL_SIDE_SIZE);

  logic [HCW-1:0] h_cnt_r;
  logic [VCW-1:0] v_cnt_r;
  logic [YW-1:0]  p1_r;
  logic [YW-1:0]  p2_r;
  logic [XW-1:0]  bx_r;
  logic [YW-1:0]  by_r;
  logic [11:0]    rgb_r;
  logic           de_r;
  logic           hsync_n_r;
  logic           vsync_n_r;
  logic           frame_tick_r;

  logic           h_last_s;
  logic           v_last_s;
  logic           latch_s;
  logic           active_s;
  logic           hs_s;
  logic           vs_s;
  logic [XW:0]    x_s;
  logic [YW:0]    y_s;
  logic           on_p1_s;
  logic           on_p2_s;
  logic           on_ball_s;
  logic           net_s;
  logic           hit_s;
  logic [11:0]    rgb_s;

  assign h_last_s = (h_cnt_r == H_LAST);
  assign v_last_s = (v_cnt_r == V_LAST);
  assign latch_s  = h_last_s && (v_cnt_r == V_LATCH);
  assign active_s = (h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C);
  assign hs_s     = (h_cnt_r >= HS_LO) && (h_cnt_r < HS_HI);
  assign vs_s     = (v_cnt_r >= VS_LO) && (v_cnt_r < VS_HI);

  // Extra headroom bit keeps right/bottom-edge objects clipped instead of wrapping to 0.
  assign x_s = (XW+1)'(h_cnt_r);
  assign y_s = (YW+1)'(v_cnt_r);

  assign on_p1_s   = (x_s >= P1_LO) && (x_s < P1_HI) &&
                     (y_s >= {1'b0, p1_r}) && (y_s < ({1'b0, p1_r} + PAD_H_C));
  assign on_p2_s   = (x_s >= P2_LO) && (x_s < P2_HI) &&
                     (y_s >= {1'b0, p2_r}) && (y_s < ({1'b0, p2_r} + PAD_H_C));
  assign on_ball_s = (x_s >= {1'b0, bx_r}) && (x_s < ({1'b0, bx_r} + BALL_X_C)) &&
                     (y_s >= {1'b0, by_r}) && (y_s < ({1'b0, by_r} + BALL_Y_C));

`ifdef PONG_CENTER_NET_EN
  localparam logic [XW:0] NET_LO = (XW+1)'(H_ACTIVE / 2 - 1);
  localparam logic [XW:0] NET_HI = (XW+1)'(H_ACTIVE / 2 + 1);
  assign net_s = (x_s >= NET_LO) && (x_s < NET_HI) && !v_cnt_r[4];
`else
  assign net_s = 1'b0;
`endif

  assign hit_s = on_p1_s || on_p2_s || on_ball_s || net_s;

  // Pixel colour selection for the current counter position.
  always_comb begin
    rgb_s = 12'h000;
    if (!active_s) begin
      rgb_s = 12'h000;
    end else if (hit_s) begin
      rgb_s = FG_COLOR;
    end else begin
      rgb_s = BG_COLOR;
    end
  end

  // Raster position counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt_r <= {HCW{1'b0}};
      v_cnt_r <= {VCW{1'b0}};
    end else if (h_last_s) begin
      h_cnt_r <= {HCW{1'b0}};
      if (v_last_s) begin
        v_cnt_r <= {VCW{1'b0}};
      end else begin
        v_cnt_r <= v_cnt_r + V_ONE;
      end
    end else begin
      h_cnt_r <= h_cnt_r + H_ONE;
    end
  end

  // Shadow positions, sampled only at the end of the last visible line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1_r <= {YW{1'b0}};
      p2_r <= {YW{1'b0}};
      bx_r <= {XW{1'b0}};
      by_r <= {YW{1'b0}};
    end else if (latch_s) begin
      p1_r <= vid.paddle_1_pos;
      p2_r <= vid.paddle_2_pos;
      bx_r <= vid.ball_pos_x;
      by_r <= vid.ball_pos_y;
    end
  end

  // Output stage: colour, enable, syncs and frame tick share one register delay.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_r        <= 12'h000;
      de_r         <= 1'b0;
      hsync_n_r    <= 1'b1;
      vsync_n_r    <= 1'b1;
      frame_tick_r <= 1'b0;
    end else begin
      rgb_r        <= rgb_s;
      de_r         <= active_s;
      hsync_n_r    <= ~hs_s;
      vsync_n_r    <= ~vs_s;
      frame_tick_r <= latch_s;
    end
  end

  assign vid.rgb        = rgb_r;
  assign vid.de         = de_r;
  assign vid.hsync_n    = hsync_n_r;
  assign vid.vsync_n    = vsync_n_r;
  assign vid.frame_tick = frame_tick_r;
endmodule

// File: doc/pong_frame_renderer.md
Name: pong_frame_renderer

Overview:
- Display-side consumer of the game controller's position outputs (`paddle_1_pos`, `paddle_2_pos`, `ball_pos_x`, `ball_pos_y`).
- Generates VGA 640x480@60 timing from a pixel-rate clock.
- Latches the positions once per frame into shadow registers, so a frame never tears.
- Rasterises two paddles and the ball into a 12-bit RGB stream with aligned syncs.

Parameters:
- H_ACTIVE, 640, visible pixels per line (equals game TOTAL_WIDTH)
- H_FRONT, 16, horizontal front porch, clocks
- H_SYNC, 96, hsync pulse width, clocks
- H_BACK, 48, horizontal back porch, clocks
- V_ACTIVE, 480, visible lines (equals game TOTAL_HEIGHT)
- V_FRONT, 10, vertical front porch, lines
- V_SYNC, 2, vsync pulse width, lines
- V_BACK, 33, vertical back porch, lines
- PADDLE_1_X, 20, left paddle left edge, pixels
- PADDLE_2_X, 610, right paddle left edge, pixels
- PADDLE_WIDTH, 10, paddle width, pixels
- PADDLE_HEIGHT, 80, paddle height, pixels
- BALL_SIDE_SIZE, 10, ball side length, pixels
- FG_COLOR, 12'hFFF, object colour {R,G,B} 4 bits each
- BG_COLOR, 12'h000, active-area background colour

Ports:
- clk  in  1  pixel clock; one pixel per cycle
- rst  in  1  asynchronous, active-low reset
- paddle_1_pos  in  YW  left paddle top row; YW = $clog2(V_ACTIVE+1)+1 (10 at defaults)
- paddle_2_pos  in  YW  right paddle top row
- ball_pos_x  in  XW  ball left column; XW = $clog2(H_ACTIVE+1)+1 (11 at defaults)
- ball_pos_y  in  YW  ball top row
- hsync_n  out  1  horizontal sync, active-low
- vsync_n  out  1  vertical sync, active-low
- rgb  out  12  pixel colour
- de  out  1  data enable; high on visible pixels
- frame_tick  out  1  one-cycle pulse when new positions are latched

Behaviour:
- **Totals:** H_TOTAL = sum of the four H params (800); V_TOTAL = sum of the four V params (525).
- **hcount:** runs 0..H_TOTAL-1, wraps to 0.
- **vcount:** increments when hcount wraps; runs 0..V_TOTAL-1, wraps to 0.
- **Reset (rst=0), async:**
  - hcount = vcount = 0.
  - Shadows: paddle shadows = 0, ball shadows = 0.
  - hsync_n = 1, vsync_n = 1, rgb = 0, de = 0, frame_tick = 0.
- **Reset mid-frame:** timing restarts at (0,0) on the first clock after release. Shadows are not re-latched until the next latch point.
- **Stage 0 (combinational from counters):**
  - `active` = hcount < H_ACTIVE && vcount < V_ACTIVE.
  - `hs` = hcount in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC).
  - `vs` = vcount in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC).
- **Hit tests** use the shadow registers; a pixel (x,y) is:
  - on paddle1 if PADDLE_1_X <= x < PADDLE_1_X+PADDLE_WIDTH and p1 <= y < p1+PADDLE_HEIGHT;
  - on paddle2 likewise with PADDLE_2_X and p2;
  - on the ball if bx <= x < bx+BALL_SIDE_SIZE and by <= y < by+BALL_SIDE_SIZE.
- **Width rule:** all sums are computed one bit wider than the operands. No wrap-around: an object near the right or bottom edge is clipped, never drawn at x or y near 0.
- **Colour:**
  - active and any hit -> FG_COLOR;
  - active and no hit -> BG_COLOR;
  - not active -> 12'h000.
- **Stage 1 (registered):** rgb, de, hsync_n = ~hs and vsync_n = ~vs are all registered together. Latency is exactly 1 clock from the counter value, and all outputs stay mutually aligned.
- **Latch point:** the cycle where hcount == H_TOTAL-1 and vcount == V_ACTIVE-1 (end of the last visible line).
  - The four inputs are sampled into the shadows on that edge.
  - frame_tick = 1 for that one cycle (registered).
- **Input changes:** changes at any other time have no effect until the next latch point. Inputs are assumed synchronous to clk (same clock domain as the controller).
- **Simultaneous overlap** (ball over paddle): FG_COLOR, no priority distinction needed.
- **Out-of-range inputs** (e.g. ball_pos_y >= V_ACTIVE): the object is simply not visible. No error.

Optional Feature:
- Macro `PONG_CENTER_NET_EN`.
- **Defined:** an additional dashed centre line is drawn in FG_COLOR.
  - x in [H_ACTIVE/2-1, H_ACTIVE/2+1), i.e. columns 319..320.
  - Only where vcount[4] == 0 (16 lines on, 16 off).
  - ORed into the hit test with the same 1-clock latency.
- **Undefined:** no net logic is present; the centre is background unless an object covers it.

Test Plan:
- **Timing after reset:** release rst, no objects on screen -> hsync_n first falls 657 clocks after release, stays low 96 clocks, period 800. vsync_n low 1600 clocks, period 420000. de high 640 of every 800 clocks on lines 0..479.
- **Paddle raster:** paddle_1_pos=100, held through a latch point. Next frame:
  - (20,100) = 12'hFFF and (29,179) = 12'hFFF;
  - (19,100), (30,179) and (20,180) = 12'h000.
- **Latch isolation:**
  - latch ball (300,200); after vcount=10 of the following frame change the input to (400,300);
  - the remainder of that frame still shows the ball at (300,200), with (400,300) dark;
  - the next frame shows (400,300), 10x10 lit;
  - frame_tick pulses exactly once per 420000 clocks.
- **Edge clipping:** ball_pos_x=635, ball_pos_y=475 -> pixels x 635..639, y 475..479 lit; x 0..4 and y 0..4 remain BG_COLOR.
- **Reset mid-frame:**
  - assert rst at hcount=300, vcount=200 -> all outputs at reset values while asserted;
  - after release, hsync_n falls 657 clocks later;
  - shadows read 0, so both paddles show at rows 0..79 and the ball at columns 0..9, rows 0..9.
- **Centre net** (`PONG_CENTER_NET_EN` defined) -> (319,0) and (320,15) = FG_COLOR; (319,16) = BG_COLOR. With the macro undefined, (319,0) = BG_COLOR.
